// File: rtl/mfm_rdgen_pkg.sv
// rtl/mfm_rdgen_pkg.sv - shared types and constants for the MFM read-pulse generator
// Contents: state_t (IDLE, RUN), mark/gap byte values, the mark's suppressed
// clock-bit position and default cell/pulse timing in fclk cycles.
package mfm_rdgen_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [7:0] MARK_BYTE      = 8'hA1;
   localparam logic [7:0] GAP_BYTE       = 8'h4E;
   localparam int         MARK_CLK_BIT   = 2;
   localparam int         DEF_CELL_CLKS  = 56;
   localparam int         DEF_PULSE_CLKS = 8;

endpackage

// File: rtl/mfm_rdgen_enc.sv
// rtl/mfm_rdgen_enc.sv - combinational MFM byte encoder
// Ports:
//   data     in  8   byte to encode, MSB first
//   prev     in  1   last data bit of the preceding byte
//   mark     in  1   suppress the bit-2 clock cell (honoured only for 8'hA1)
//   cells    out 16  cell word, cells[15] is the clock cell of data bit 7
//   prev_out out 1   last data bit of this byte, for chaining
module mfm_rdgen_enc
   import mfm_rdgen_pkg::*;
(
   input  logic [7:0]  data,
   input  logic        prev,
   input  logic        mark,
   output logic [15:0] cells,
   output logic        prev_out
);

   logic mark_eff;
   logic p;
   logic c;

   assign mark_eff = mark & (data == MARK_BYTE);
   assign prev_out = data[0];

   // Walk the bits MSB first, shifting in (clock, data) pairs.
   always_comb begin
      cells = '0;
      p     = prev;
      c     = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         c = ~p & ~data[i];
         if (mark_eff && (i == MARK_CLK_BIT)) begin
            c = 1'b0;
         end
         cells = {cells[13:0], c, data[i]};
         p     = data[i];
      end
   end

endmodule

// File: rtl/mfm_rdgen.sv
// rtl/mfm_rdgen.sv - MFM read-pulse generator feeding the vg93 rdat_n input
// Optional feature macro: MFM_RDGEN_GAPFILL_EN (on underrun, stream 8'h4E
// gap bytes instead of dropping to IDLE).
// Ports:
//   fclk       in  1  28 MHz clock
//   rst_n      in  1  asynchronous active-low reset
//   enable     in  1  level enable; low forces idle
//   byte_data  in  8  byte to encode, MSB first
//   byte_mark  in  1  with 8'hA1, emit the 4489 sync mark
//   byte_valid in  1  upstream holds a byte
//   byte_ready out 1  holding register empty and enabled
//   rdat_n     out 1  active-low flux pulse
//   underrun   out 1  one-clock strobe at a byte boundary with nothing held
//   busy       out 1  generator in RUN
module mfm_rdgen
   import mfm_rdgen_pkg::*;
#(
   parameter int CELL_CLKS  = DEF_CELL_CLKS,
   parameter int PULSE_CLKS = DEF_PULSE_CLKS
) (
   input  logic       fclk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic [7:0] byte_data,
   input  logic       byte_mark,
   input  logic       byte_valid,
   output logic       byte_ready,
   output logic       rdat_n,
   output logic       underrun,
   output logic       busy
);

   localparam int             TW        = $clog2(CELL_CLKS);
   localparam int             PW        = $clog2(PULSE_CLKS + 1);
   localparam logic [TW-1:0]  TIMER_MAX = TW'(CELL_CLKS - 1);
   localparam logic [PW-1:0]  PULSE_LD  = PW'(PULSE_CLKS);

   state_t        state;
   state_t        state_nxt;
   logic          hold_full;
   logic [7:0]    hold_data;
   logic          hold_mark;
   logic [15:0]   shifter;
   logic          prev_bit;
   logic [TW-1:0] timer;
   logic [3:0]    idx;
   logic [3:0]    idx_nxt;
   logic [PW-1:0] pcnt;

   logic          load;
   logic          use_gap;
   logic          cell_adv;
   logic          ur_det;
   logic          xfer;
   logic          cell_bit;

   logic [7:0]    enc_data;
   logic          enc_mark;
   logic          enc_prev;
   logic [15:0]   enc_cells;
   logic          enc_prev_out;

   assign byte_ready = enable & ~hold_full;
   assign xfer       = byte_valid & byte_ready;
   assign busy       = (state == RUN);

   // One encoder serves both the held byte and the gap byte. Coming out of
   // IDLE the stream restarts with prev=0.
   assign enc_data = use_gap ? GAP_BYTE : hold_data;
   assign enc_mark = use_gap ? 1'b0 : hold_mark;
   assign enc_prev = (state == RUN) & prev_bit;

   mfm_rdgen_enc u_enc (
      .data     (enc_data),
      .prev     (enc_prev),
      .mark     (enc_mark),
      .cells    (enc_cells),
      .prev_out (enc_prev_out)
   );

   // Value of the cell starting on this clock. For 4-bit idx, 15-idx == ~idx.
   assign idx_nxt  = idx + 4'd1;
   assign cell_bit = load ? enc_cells[15] : shifter[~idx_nxt];

   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      use_gap   = 1'b0;
      cell_adv  = 1'b0;
      ur_det    = 1'b0;
      if (enable) begin
         case (state)
            IDLE: begin
               if (hold_full) begin
                  load      = 1'b1;
                  state_nxt = RUN;
               end
            end
            RUN: begin
               if (timer == '0) begin
                  if (idx == 4'd15) begin
                     if (hold_full) begin
                        load = 1'b1;
                     end else begin
                        ur_det = 1'b1;
`ifdef MFM_RDGEN_GAPFILL_EN
                        load    = 1'b1;
                        use_gap = 1'b1;
`else
                        state_nxt = IDLE;
`endif
                     end
                  end else begin
                     cell_adv = 1'b1;
                  end
               end
            end
            default: state_nxt = IDLE;
         endcase
      end else begin
         state_nxt = IDLE;
      end
   end

   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         hold_full <= 1'b0;
         hold_data <= '0;
         hold_mark <= 1'b0;
         shifter   <= '0;
         prev_bit  <= 1'b0;
         timer     <= '0;
         idx       <= '0;
         pcnt      <= '0;
         rdat_n    <= 1'b1;
         underrun  <= 1'b0;
      end else if (!enable) begin
         hold_full <= 1'b0;
         prev_bit  <= 1'b0;
         timer     <= '0;
         idx       <= '0;
         pcnt      <= '0;
         rdat_n    <= 1'b1;
         underrun  <= 1'b0;
      end else begin
         underrun <= ur_det;

         // A byte taken on the boundary clock only fills the holding
         // register; it is picked up from IDLE (or after the gap byte).
         if (xfer) begin
            hold_full <= 1'b1;
            hold_data <= byte_data;
            hold_mark <= byte_mark;
         end else if (load && !use_gap) begin
            hold_full <= 1'b0;
         end

         if (load) begin
            shifter  <= enc_cells;
            prev_bit <= enc_prev_out;
            idx      <= '0;
            timer    <= TIMER_MAX;
         end else if (cell_adv) begin
            idx   <= idx_nxt;
            timer <= TIMER_MAX;
         end else if (ur_det) begin
            idx      <= '0;
            prev_bit <= 1'b0;
         end else if (state == RUN) begin
            timer <= timer - 1'b1;
         end

         if ((load || cell_adv) && cell_bit) begin
            pcnt <= PULSE_LD;
         end else if (pcnt != '0) begin
            pcnt <= pcnt - 1'b1;
         end

         rdat_n <= (state == RUN) ? (pcnt == '0) : 1'b1;
      end
   end

endmodule
